// File: rtl/regfile_pkg.sv
// Shared constants, width helpers and read-port types for the scoreboarded register file.
package regfile_pkg;

  localparam int unsigned DEFAULT_DATA_WIDTH = 32;
  localparam int unsigned DEFAULT_NUM_REGS   = 32;

  function automatic int unsigned addr_width(input int unsigned num_regs);
    return (num_regs > 1) ? $clog2(num_regs) : 1;
  endfunction

  function automatic int unsigned cnt_width(input int unsigned max_inflight);
    return (max_inflight > 0) ? $clog2(max_inflight + 1) : 1;
  endfunction

  typedef logic [DEFAULT_DATA_WIDTH-1:0]           reg_data_t;
  typedef logic [addr_width(DEFAULT_NUM_REGS)-1:0] reg_addr_t;

  typedef struct packed {
    reg_data_t data;
    logic      busy;
  } read_resp_t;

endpackage

// File: rtl/regfile_scoreboard_if.sv
// Issue/writeback-facing bus of the register file: read ports, writeback, reservations, flush.
interface regfile_scoreboard_if
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = DEFAULT_DATA_WIDTH,
  parameter int unsigned NUM_REGS       = DEFAULT_NUM_REGS,
  parameter int unsigned NUM_READ_PORTS = 2
);
  localparam int unsigned ADDR_WIDTH = addr_width(NUM_REGS);

  logic [NUM_READ_PORTS-1:0][ADDR_WIDTH-1:0] readAddress;
  logic [NUM_READ_PORTS-1:0][DATA_WIDTH-1:0] readData;
  logic [NUM_READ_PORTS-1:0]                 readBusy;
  logic                                      writeEnable;
  logic [ADDR_WIDTH-1:0]                     writeAddress;
  logic [DATA_WIDTH-1:0]                     writeData;
  logic                                      reserveEnable;
  logic [ADDR_WIDTH-1:0]                     reserveAddress;
  logic                                      reserveReady;
  logic                                      flush;

  modport master (
    output readAddress, writeEnable, writeAddress, writeData,
           reserveEnable, reserveAddress, flush,
    input  readData, readBusy, reserveReady
  );

  modport slave (
    input  readAddress, writeEnable, writeAddress, writeData,
           reserveEnable, reserveAddress, flush,
    output readData, readBusy, reserveReady
  );
endinterface

// File: rtl/regfile_pending_counter.sv
// Per-register outstanding-producer counter: saturating up/down, clear has priority.
module regfile_pending_counter
  import regfile_pkg::*;
#(
  parameter int unsigned MAX_INFLIGHT = 3,
  parameter int unsigned CNT_WIDTH    = cnt_width(MAX_INFLIGHT)
) (
  input  logic                 clock,
  input  logic                 resetN,
  input  logic                 inc_i,
  input  logic                 dec_i,
  input  logic                 clr_i,
  output logic [CNT_WIDTH-1:0] count_o,
  output logic                 full_o
);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(MAX_INFLIGHT);

  logic [CNT_WIDTH-1:0] count_q, count_d;
  logic                 full_q, full_d;

  // Simultaneous inc and dec cancel; dec at zero holds.
  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (inc_i && !dec_i && (count_q != CNT_MAX)) begin
      count_d = count_q + CNT_WIDTH'(1);
    end else if (dec_i && !inc_i && (count_q != '0)) begin
      count_d = count_q - CNT_WIDTH'(1);
    end
    full_d = (count_d == CNT_MAX);
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      count_q <= '0;
      full_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      full_q  <= full_d;
    end
  end

  assign count_o = count_q;
  assign full_o  = full_q;
endmodule

// File: rtl/regfile_scoreboard.sv
// Multi-port integer register file with write bypass and per-register in-flight scoreboard.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = DEFAULT_DATA_WIDTH,
  parameter int unsigned NUM_REGS       = DEFAULT_NUM_REGS,
  parameter int unsigned NUM_READ_PORTS = 2,
  parameter int unsigned ZERO_REG       = 1,
  parameter int unsigned BYPASS_EN      = 1,
  parameter int unsigned MAX_INFLIGHT   = 3
) (
  input  logic                clock,
  input  logic                resetN,
  regfile_scoreboard_if.slave rf
);
  localparam int unsigned ADDR_WIDTH = addr_width(NUM_REGS);
  localparam int unsigned CNT_WIDTH  = cnt_width(MAX_INFLIGHT);
  localparam bit          HAS_ZERO   = (ZERO_REG != 0);
  localparam bit          HAS_BYPASS = (BYPASS_EN != 0);

  logic [DATA_WIDTH-1:0]               regs_q [NUM_REGS];
  logic [NUM_REGS-1:0][CNT_WIDTH-1:0]  cnt;
  logic [NUM_REGS-1:0]                 full;
  logic                                wr_valid, wr_commit;
  logic                                rsv_valid, rsv_ready, rsv_accept;
  logic [NUM_READ_PORTS-1:0][DATA_WIDTH-1:0] rd_data;
  logic [NUM_READ_PORTS-1:0]                 rd_busy;

  function automatic logic in_range(input logic [ADDR_WIDTH-1:0] addr);
    return 32'(addr) < NUM_REGS;
  endfunction

  function automatic logic is_zero_reg(input logic [ADDR_WIDTH-1:0] addr);
    return HAS_ZERO && (addr == '0);
  endfunction

  assign wr_valid  = rf.writeEnable && in_range(rf.writeAddress);
  assign wr_commit = wr_valid && !is_zero_reg(rf.writeAddress);
  assign rsv_valid = in_range(rf.reserveAddress);

  // A same-cycle write to the reserved register frees the slot it would need.
  assign rsv_ready  = !resetN || !rsv_valid || !full[rf.reserveAddress]
                    || (rf.writeEnable && (rf.writeAddress == rf.reserveAddress));
  assign rsv_accept = rf.reserveEnable && rsv_ready && rsv_valid
                    && !is_zero_reg(rf.reserveAddress);

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      for (int i = 0; i < int'(NUM_REGS); i++) begin
        regs_q[i] <= '0;
      end
    end else if (wr_commit) begin
      regs_q[rf.writeAddress] <= rf.writeData;
    end
  end

  for (genvar g = 0; g < int'(NUM_REGS); g++) begin : g_reg
    if (HAS_ZERO && (g == 0)) begin : g_hardwired
      assign cnt[g]  = '0;
      assign full[g] = 1'b0;
    end else begin : g_tracked
      logic inc, dec;
      assign inc = rsv_accept && (rf.reserveAddress == ADDR_WIDTH'(g));
      assign dec = wr_valid   && (rf.writeAddress   == ADDR_WIDTH'(g));

      regfile_pending_counter #(
        .MAX_INFLIGHT (MAX_INFLIGHT),
        .CNT_WIDTH    (CNT_WIDTH)
      ) u_cnt (
        .clock   (clock),
        .resetN  (resetN),
        .inc_i   (inc),
        .dec_i   (dec),
        .clr_i   (rf.flush),
        .count_o (cnt[g]),
        .full_o  (full[g])
      );
    end
  end

  // Bypassed reads see the producer being retired, so only further producers keep it busy.
  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    for (int p = 0; p < int'(NUM_READ_PORTS); p++) begin
      if (resetN && in_range(rf.readAddress[p]) && !is_zero_reg(rf.readAddress[p])) begin
        if (HAS_BYPASS && wr_valid && (rf.writeAddress == rf.readAddress[p])) begin
          rd_data[p] = rf.writeData;
          rd_busy[p] = cnt[rf.readAddress[p]] > CNT_WIDTH'(1);
        end else begin
          rd_data[p] = regs_q[rf.readAddress[p]];
          rd_busy[p] = cnt[rf.readAddress[p]] != '0;
        end
      end
    end
  end

  assign rf.readData     = rd_data;
  assign rf.readBusy     = rd_busy;
  assign rf.reserveReady = rsv_ready;
endmodule

// File: tb/tb_regfile_scoreboard.sv
// Scoreboard bench: two configurations driven in lockstep, expectations from an array-based model.
module tb_regfile_scoreboard;
  import regfile_pkg::*;

  localparam int NP   = 2;
  localparam int MAXI = 3;
  localparam int NDUT = 2;
  localparam int NR_A = 32;
  localparam int NR_B = 24;

  typedef struct packed {
    logic [31:0]            cyc;
    read_resp_t [NP-1:0]    resp;
    logic                   rr;
  } exp_t;

  logic clock = 1'b0;
  logic resetN;
  always #5 clock = ~clock;

  regfile_scoreboard_if #(.NUM_REGS(NR_A), .NUM_READ_PORTS(NP)) if_a ();
  regfile_scoreboard_if #(.NUM_REGS(NR_B), .NUM_READ_PORTS(NP)) if_b ();

  regfile_scoreboard #(
    .NUM_REGS(NR_A), .NUM_READ_PORTS(NP), .ZERO_REG(1), .BYPASS_EN(1), .MAX_INFLIGHT(MAXI)
  ) dut_a (.clock(clock), .resetN(resetN), .rf(if_a.slave));

  regfile_scoreboard #(
    .NUM_REGS(NR_B), .NUM_READ_PORTS(NP), .ZERO_REG(0), .BYPASS_EN(0), .MAX_INFLIGHT(MAXI)
  ) dut_b (.clock(clock), .resetN(resetN), .rf(if_b.slave));

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [4:0]  cur_ra [NP];
  logic        cur_we, cur_re, cur_fl, cur_rn;
  logic [4:0]  cur_wa, cur_rsa;
  logic [31:0] cur_wd;

  int unsigned m_regs [NDUT][32];
  int          m_cnt  [NDUT][32];
  int          cfg_nr   [NDUT] = '{NR_A, NR_B};
  bit          cfg_zero [NDUT] = '{1'b1, 1'b0};
  bit          cfg_byp  [NDUT] = '{1'b1, 1'b0};

  exp_t q_a[$];
  exp_t q_b[$];

  task automatic chk(input string nm, input int c, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s cyc %0d actual %h required %h", nm, c, act, req);
    end
  endtask

  // Reference model: outputs from the current state and inputs, then the clock-edge update.
  task automatic model_step(input int k, output exp_t e);
    int  a, ins, del;
    bit  rdy;
    e = '0;
    e.cyc = 32'(cyc);
    if (!cur_rn) begin
      for (int i = 0; i < 32; i++) begin
        m_regs[k][i] = 0;
        m_cnt[k][i]  = 0;
      end
    end
    for (int p = 0; p < NP; p++) begin
      a = int'(cur_ra[p]);
      if (cur_rn && a < cfg_nr[k] && !(cfg_zero[k] && a == 0)) begin
        if (cfg_byp[k] && cur_we && int'(cur_wa) == a) begin
          e.resp[p].data = cur_wd;
          e.resp[p].busy = m_cnt[k][a] > 1;
        end else begin
          e.resp[p].data = m_regs[k][a];
          e.resp[p].busy = m_cnt[k][a] != 0;
        end
      end
    end
    a = int'(cur_rsa);
    if (!cur_rn || a >= cfg_nr[k]) rdy = 1'b1;
    else rdy = (m_cnt[k][a] != MAXI) || (cur_we && cur_wa == cur_rsa);
    e.rr = rdy;
    if (cur_rn) begin
      del = (cur_we && int'(cur_wa) < cfg_nr[k] && !(cfg_zero[k] && cur_wa == 5'd0)) ? int'(cur_wa) : -1;
      ins = (cur_re && rdy && a < cfg_nr[k] && !(cfg_zero[k] && a == 0)) ? a : -1;
      if (del >= 0) m_regs[k][del] = cur_wd;
      if (cur_fl) begin
        for (int i = 0; i < 32; i++) m_cnt[k][i] = 0;
      end else if (ins != del) begin
        if (ins >= 0) m_cnt[k][ins] = m_cnt[k][ins] + 1;
        if (del >= 0 && m_cnt[k][del] > 0) m_cnt[k][del] = m_cnt[k][del] - 1;
      end
    end
  endtask

  task automatic step(input logic [4:0] r0, input logic [4:0] r1, input logic we,
                      input logic [4:0] wa, input logic [31:0] wd, input logic re,
                      input logic [4:0] rsa, input logic fl, input logic rn);
    exp_t e;
    @(negedge clock);
    cur_ra[0] = r0; cur_ra[1] = r1;
    cur_we = we; cur_wa = wa; cur_wd = wd;
    cur_re = re; cur_rsa = rsa; cur_fl = fl; cur_rn = rn;
    resetN = rn;
    for (int p = 0; p < NP; p++) begin
      if_a.readAddress[p] = cur_ra[p];
      if_b.readAddress[p] = cur_ra[p];
    end
    if_a.writeEnable = we;   if_b.writeEnable = we;
    if_a.writeAddress = wa;  if_b.writeAddress = wa;
    if_a.writeData = wd;     if_b.writeData = wd;
    if_a.reserveEnable = re; if_b.reserveEnable = re;
    if_a.reserveAddress = rsa; if_b.reserveAddress = rsa;
    if_a.flush = fl;         if_b.flush = fl;
    model_step(0, e); q_a.push_back(e);
    model_step(1, e); q_b.push_back(e);
    cyc++;
  endtask

  task automatic idle(input logic [4:0] r0, input logic [4:0] r1);
    step(r0, r1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0, 1'b1);
  endtask

  task automatic compare_dut(input int k, input exp_t e);
    logic [31:0] d;
    logic        b, r;
    for (int p = 0; p < NP; p++) begin
      d = (k == 0) ? if_a.readData[p] : if_b.readData[p];
      b = (k == 0) ? if_a.readBusy[p] : if_b.readBusy[p];
      chk($sformatf("dut%0d_readData%0d", k, p), int'(e.cyc), d, e.resp[p].data);
      chk($sformatf("dut%0d_readBusy%0d", k, p), int'(e.cyc), 32'(b), 32'(e.resp[p].busy));
    end
    r = (k == 0) ? if_a.reserveReady : if_b.reserveReady;
    chk($sformatf("dut%0d_reserveReady", k), int'(e.cyc), 32'(r), 32'(e.rr));
  endtask

  // Monitor: samples mid low-phase, after the driver has settled the inputs.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      #3;
      while (q_a.size() > 0) begin e = q_a.pop_front(); compare_dut(0, e); end
      while (q_b.size() > 0) begin e = q_b.pop_front(); compare_dut(1, e); end
    end
  end

  function automatic logic [4:0] rnd_addr();
    if ($urandom_range(0, 3) == 0) return 5'($urandom_range(0, 31));
    return 5'($urandom_range(0, 7));
  endfunction

  initial begin
    resetN = 1'b1;
    #1 resetN = 1'b0;
    step(5'd5, 5'd5, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    step(5'd5, 5'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 1'b0, 1'b0);
    idle(5'd0, 5'd1);

    // asynchronous reset after a write and a pending reservation
    step(5'd5, 5'd5, 1'b1, 5'd5, 32'hDEADBEEF, 1'b1, 5'd5, 1'b0, 1'b1);
    step(5'd5, 5'd5, 1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 1'b0, 1'b1);
    idle(5'd5, 5'd5);
    step(5'd5, 5'd5, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    idle(5'd5, 5'd5);

    // register 0 write
    step(5'd0, 5'd0, 1'b1, 5'd0, 32'h12345678, 1'b1, 5'd0, 1'b0, 1'b1);
    idle(5'd0, 5'd0);

    // bypass against a pending producer
    step(5'd7, 5'd7, 1'b1, 5'd7, 32'h11110000, 1'b0, 5'd0, 1'b0, 1'b1);
    step(5'd7, 5'd7, 1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 1'b0, 1'b1);
    step(5'd7, 5'd7, 1'b1, 5'd7, 32'hA5A5A5A5, 1'b0, 5'd0, 1'b0, 1'b1);
    idle(5'd7, 5'd7);

    // saturation at MAX_INFLIGHT and same-cycle reserve+write
    repeat (4) step(5'd3, 5'd3, 1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 1'b0, 1'b1);
    step(5'd3, 5'd3, 1'b1, 5'd3, 32'h00000033, 1'b0, 5'd3, 1'b0, 1'b1);
    idle(5'd3, 5'd3);
    step(5'd3, 5'd3, 1'b1, 5'd3, 32'h00000034, 1'b1, 5'd3, 1'b0, 1'b1);
    step(5'd3, 5'd3, 1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 1'b0, 1'b1);
    step(5'd3, 5'd3, 1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 1'b0, 1'b1);

    // flush with concurrent reserve and write
    step(5'd4, 5'd9, 1'b0, 5'd0, 32'd0, 1'b1, 5'd4, 1'b0, 1'b1);
    step(5'd4, 5'd9, 1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 1'b0, 1'b1);
    step(5'd9, 5'd11, 1'b1, 5'd9, 32'd7, 1'b1, 5'd11, 1'b1, 1'b1);
    idle(5'd9, 5'd11);
    idle(5'd4, 5'd3);

    // write with no pending producer
    step(5'd6, 5'd6, 1'b1, 5'd6, 32'h00000066, 1'b0, 5'd0, 1'b0, 1'b1);
    idle(5'd6, 5'd6);

    // out-of-range accesses on the 24-entry configuration
    step(5'd25, 5'd31, 1'b1, 5'd27, 32'hCAFE0001, 1'b1, 5'd30, 1'b0, 1'b1);
    idle(5'd27, 5'd30);

    repeat (600) begin
      step(rnd_addr(), rnd_addr(), 1'($urandom_range(0, 1)), rnd_addr(), $urandom(),
           1'($urandom_range(0, 9) < 6), rnd_addr(), 1'($urandom_range(0, 19) == 0), 1'b1);
    end
    idle(5'd0, 5'd0);

    for (int i = 0; i < 10 && (q_a.size() != 0 || q_b.size() != 0); i++) @(negedge clock);
    #5;
    checks++;
    if (q_a.size() != 0 || q_b.size() != 0) begin
      errors++;
      $display("FAIL drain actual %0d required 0", q_a.size() + q_b.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
